// File: rtl/sonar_adc_capture_ctrl.sv
// sonar_adc_capture_ctrl
//   Runs one 14-bit serial SONAR ADC conversion per accepted start: drops
//   chip select, toggles the serial clock, shifts adc_sdo in MSB-first on each
//   sclk rising edge, then presents the sample over a valid/ready handshake.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           conversion request (sampled when idle)
//   test_mode       use pattern counter instead of ADC data (optional build)
//   busy            conversion or quiet period in progress
//   adc_cs_n        ADC chip select, active low
//   adc_sclk        ADC serial clock
//   adc_sdo         ADC serial data, MSB first
//   sample_data     captured sample, stable while sample_valid is high
//   sample_valid    sample available
//   sample_ready    consumer accepts sample
//   overrun         sticky: an unaccepted sample was overwritten
//
// Build option: define SONAR_ADC_TEST_PATTERN_EN to enable the test-pattern
// counter selected by test_mode; otherwise test_mode is ignored.
module sonar_adc_capture_ctrl #(
    parameter int unsigned DATA_W       = 14,
    parameter int unsigned SCLK_DIV     = 4,
    parameter int unsigned QUIET_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              test_mode,
    output logic              busy,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    input  logic              adc_sdo,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
);

    localparam int unsigned DIV_W = $clog2(SCLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned QW    = $clog2(QUIET_CYCLES + 2);

    if (DATA_W != 14) begin : g_bad_width
        $error("sonar_adc_capture_ctrl: DATA_W must be 14");
    end
    if (SCLK_DIV < 1) begin : g_bad_div
        $error("sonar_adc_capture_ctrl: SCLK_DIV must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        DONE     = 3'd3,
        QUIET    = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [DIV_W-1:0]    div_cnt, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [QW-1:0]       quiet_cnt, quiet_cnt_d;
    logic [DATA_W-1:0]   shreg, shreg_d;
    logic [DATA_W-1:0]   sample_data_d;
    logic                busy_d, cs_n_d, sclk_d, valid_d, overrun_d;
    logic                go_setup, quiet_done, load;
    logic [DATA_W-1:0]   sample_in;

`ifdef SONAR_ADC_TEST_PATTERN_EN
    logic [DATA_W-1:0]   pat_cnt, pat_cnt_d;
`else
    logic                unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            quiet_cnt    <= '0;
            shreg        <= '0;
            busy         <= 1'b0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
`ifdef SONAR_ADC_TEST_PATTERN_EN
            pat_cnt      <= '0;
`endif
        end else begin
            state        <= state_d;
            div_cnt      <= div_cnt_d;
            bit_cnt      <= bit_cnt_d;
            quiet_cnt    <= quiet_cnt_d;
            shreg        <= shreg_d;
            busy         <= busy_d;
            adc_cs_n     <= cs_n_d;
            adc_sclk     <= sclk_d;
            sample_data  <= sample_data_d;
            sample_valid <= valid_d;
            overrun      <= overrun_d;
`ifdef SONAR_ADC_TEST_PATTERN_EN
            pat_cnt      <= pat_cnt_d;
`endif
        end
    end

    // Next-state, sequencing and handshake logic
    always_comb begin
        state_d       = state;
        div_cnt_d     = div_cnt;
        bit_cnt_d     = bit_cnt;
        quiet_cnt_d   = quiet_cnt;
        shreg_d       = shreg;
        busy_d        = busy;
        cs_n_d        = adc_cs_n;
        sclk_d        = adc_sclk;
        sample_data_d = sample_data;
        valid_d       = sample_valid;
        overrun_d     = overrun;
        go_setup      = 1'b0;
        quiet_done    = 1'b0;
        load          = 1'b0;
        sample_in     = shreg;
`ifdef SONAR_ADC_TEST_PATTERN_EN
        pat_cnt_d     = pat_cnt;
`endif

        case (state)
            IDLE: begin
                if (start) go_setup = 1'b1;
            end
            CS_SETUP: begin
                if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    if (!adc_sclk) begin
                        // Rising sclk edge: capture the bit the ADC is presenting
                        sclk_d    = 1'b1;
                        shreg_d   = {shreg[DATA_W-2:0], adc_sdo};
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                    end else if (bit_cnt == BIT_W'(DATA_W)) begin
                        sclk_d      = 1'b0;
                        cs_n_d      = 1'b1;
                        quiet_cnt_d = '0;
                        state_d     = DONE;
                        load        = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            DONE: begin
                if (QUIET_CYCLES == 0) quiet_done = 1'b1;
                else                   state_d    = QUIET;
            end
            QUIET: begin
                if (quiet_cnt == QW'(QUIET_CYCLES - 1)) quiet_done  = 1'b1;
                else                                    quiet_cnt_d = quiet_cnt + QW'(1);
            end
            default: state_d = IDLE;
        endcase

        // The last quiet cycle samples start like IDLE does, so a held start
        // restarts exactly QUIET_CYCLES+1 cycles after DONE.
        if (quiet_done) begin
            if (start) begin
                go_setup = 1'b1;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end

        if (go_setup) begin
            state_d   = CS_SETUP;
            busy_d    = 1'b1;
            cs_n_d    = 1'b0;
            sclk_d    = 1'b0;
            shreg_d   = '0;
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end

`ifdef SONAR_ADC_TEST_PATTERN_EN
        if (load) begin
            if (test_mode) begin
                sample_in = pat_cnt;
                shreg_d   = pat_cnt;
            end
            pat_cnt_d = pat_cnt + DATA_W'(1);
        end
`endif

        // A new sample wins over consumption; overwrite of unaccepted data is sticky
        if (load) begin
            sample_data_d = sample_in;
            valid_d       = 1'b1;
            if (sample_valid && !sample_ready) overrun_d = 1'b1;
        end else if (sample_valid && sample_ready) begin
            valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_sonar_adc_capture_ctrl.sv
// Directed bench for sonar_adc_capture_ctrl (default parameters).
module tb_sonar_adc_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        test_mode;
    logic        busy;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_sdo;
    logic [13:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    sonar_adc_capture_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .test_mode    (test_mode),
        .busy         (busy),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .adc_sdo      (adc_sdo),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // ADC model: next word loads when chip select falls, one bit per sclk rise
    logic [13:0] tx_q[$];
    logic [13:0] cur_word = 14'h0;
    int          bit_idx  = 0;

    always @(posedge adc_sclk or negedge adc_cs_n) begin
        if (adc_sclk) begin
            bit_idx = bit_idx + 1;
        end else begin
            bit_idx = 0;
            if (tx_q.size() > 0) cur_word = tx_q.pop_front();
        end
    end

    assign adc_sdo = (!adc_cs_n && bit_idx < 14) ? cur_word[4'(13 - bit_idx)] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for chip select to rise (DONE edge); sampled on negedges
    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (adc_cs_n) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        chk({tag, "_idle_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] b2b_exp [3];
        logic [13:0] pat_w   [4];
        int nr, cs_low, nv, hi_run, gaps;
        logic prev_sclk, prev_cs;

        b2b_exp = '{14'h0000, 14'h3FFF, 14'h1555};
        pat_w   = '{14'h2A5C, 14'h0F0F, 14'h1111, 14'h3ABC};

        reset = 1'b1; start = 1'b0; test_mode = 1'b0; sample_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n",    32'(adc_cs_n),     32'd1);
        chk("rst_sclk",    32'(adc_sclk),     32'd0);
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_valid",   32'(sample_valid), 32'd0);
        chk("rst_data",    32'(sample_data),  32'd0);
        chk("rst_overrun", 32'(overrun),      32'd0);
        reset = 1'b0;

        // Single conversion: timing of cs_n, sclk rises and valid
        tx_q.push_back(14'h2A5C);
        sample_ready = 1'b1;
        pulse_start();
        nr = 0; cs_low = 0; prev_sclk = 1'b0;
        for (int k = 0; k <= 117; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("e0_busy", 32'(busy),     32'd1);
                chk("e0_cs_n", 32'(adc_cs_n), 32'd0);
            end
            if (adc_sclk && !prev_sclk) begin
                nr++;
                chk("rise_time", 32'(k), 32'(8 * nr));
            end
            prev_sclk = adc_sclk;
            if (!adc_cs_n) cs_low++;
            if (k == 115) chk("valid_pre", 32'(sample_valid), 32'd0);
            if (k == 116) begin
                chk("valid_done", 32'(sample_valid), 32'd1);
                chk("data_done",  32'(sample_data),  32'h2A5C);
                chk("cs_n_done",  32'(adc_cs_n),     32'd1);
                chk("sclk_done",  32'(adc_sclk),     32'd0);
            end
            if (k == 117) chk("valid_drop", 32'(sample_valid), 32'd0);
        end
        chk("rise_count",   32'(nr),     32'd14);
        chk("cs_low_cycles", 32'(cs_low), 32'd116);
        wait_idle("t1");

        // Back-to-back conversions with start held high
        foreach (b2b_exp[i]) tx_q.push_back(b2b_exp[i]);
        @(negedge clk);
        start = 1'b1;
        nv = 0; hi_run = 0; gaps = 0; prev_cs = 1'b1;
        for (int c = 0; c < 450 && nv < 3; c++) begin
            @(negedge clk);
            if (sample_valid) begin
                chk("b2b_data", 32'(sample_data), 32'(b2b_exp[nv]));
                nv++;
                if (nv == 3) start = 1'b0;
            end
            if (adc_cs_n) begin
                hi_run++;
            end else begin
                if (prev_cs && nv > 0) begin
                    chk("b2b_gap", 32'(hi_run), 32'd3);
                    gaps++;
                end
                hi_run = 0;
            end
            prev_cs = adc_cs_n;
        end
        chk("b2b_count", 32'(nv),   32'd3);
        chk("b2b_gaps",  32'(gaps), 32'd2);
        wait_idle("t2");

        // Unaccepted sample overwritten -> overrun; reset clears it
        sample_ready = 1'b0;
        tx_q.push_back(14'h0001);
        pulse_start();
        wait_done("t3a");
        chk("ovr1_data",    32'(sample_data), 32'h0001);
        chk("ovr1_overrun", 32'(overrun),     32'd0);
        wait_idle("t3a");
        chk("ovr1_hold",    32'(sample_data), 32'h0001);
        tx_q.push_back(14'h0002);
        pulse_start();
        wait_done("t3b");
        chk("ovr2_data",    32'(sample_data),  32'h0002);
        chk("ovr2_valid",   32'(sample_valid), 32'd1);
        chk("ovr2_overrun", 32'(overrun),      32'd1);
        wait_idle("t3b");
        apply_reset();
        chk("ovr_clr",       32'(overrun),      32'd0);
        chk("ovr_clr_valid", 32'(sample_valid), 32'd0);

        // Ready exactly on the second DONE edge: no overrun
        tx_q.push_back(14'h0AAA);
        pulse_start();
        wait_done("t4a");
        wait_idle("t4a");
        tx_q.push_back(14'h0555);
        pulse_start();
        repeat (116) @(negedge clk);
        chk("rdy_hold_data", 32'(sample_data),  32'h0AAA);
        chk("rdy_hold_vld",  32'(sample_valid), 32'd1);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        chk("rdy_done_valid",   32'(sample_valid), 32'd1);
        chk("rdy_done_data",    32'(sample_data),  32'h0555);
        chk("rdy_done_overrun", 32'(overrun),      32'd0);
        wait_idle("t4b");

        // Reset during bit 7 of SHIFT aborts without presenting a sample
        tx_q.push_back(14'h3C3C);
        pulse_start();
        repeat (59) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs_n",  32'(adc_cs_n),     32'd1);
        chk("abort_sclk",  32'(adc_sclk),     32'd0);
        chk("abort_busy",  32'(busy),         32'd0);
        chk("abort_valid", 32'(sample_valid), 32'd0);
        chk("abort_data",  32'(sample_data),  32'd0);
        reset = 1'b0;
        sample_ready = 1'b1;
        tx_q.push_back(14'h1234);
        pulse_start();
        wait_done("t5");
        chk("fresh_data",  32'(sample_data),  32'h1234);
        chk("fresh_valid", 32'(sample_valid), 32'd1);
        wait_idle("t5");

        // test_mode: pattern counter when built with the option, ADC data otherwise
        apply_reset();
        test_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(pat_w[i]);
            pulse_start();
            wait_done("t6");
`ifdef SONAR_ADC_TEST_PATTERN_EN
            chk("pattern_data", 32'(sample_data), 32'(i));
`else
            chk("pattern_data", 32'(sample_data), 32'(pat_w[i]));
`endif
            wait_idle("t6");
        end
        test_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sonar_adc_capture_ctrl.md
Name: sonar_adc_capture_ctrl

Overview:
- Sequences a 14-bit serial SONAR ADC conversion: drives chip select and serial clock, and shifts ADC serial data MSB-first into an internal 14-bit shift register with enable and parallel-load select.
- Presents each completed sample to downstream logic over a valid/ready handshake.
- Sits between the SONAR ADC pins and the sample buffer/correlator.

Parameters:
- DATA_W, 14, sample width; fixed at 14, checked at elaboration.
- SCLK_DIV, 4, clk cycles per half-period of adc_sclk; legal values >= 1.
- QUIET_CYCLES, 2, clk cycles adc_cs_n stays high after a conversion before the next start is accepted; legal values >= 0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request one conversion; sampled only in IDLE.
- test_mode  in  1  select test pattern; used only under TEST_PATTERN_EN.
- busy  out  1  high from start acceptance to the end of QUIET.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock.
- adc_sdo  in  1  ADC serial data, MSB first.
- sample_data  out  14  captured sample, held stable while sample_valid is high.
- sample_valid  out  1  sample available.
- sample_ready  in  1  consumer accepts the sample.
- overrun  out  1  sticky: an unaccepted sample was overwritten.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: adc_cs_n=1, adc_sclk=0, busy=0, sample_valid=0, sample_data=0, overrun=0, shift register=0, state=IDLE. Reset asserted mid-conversion aborts at the next edge with these values; no partial sample is ever presented.
- States: IDLE, CS_SETUP, SHIFT, DONE, QUIET.
- IDLE:
  - adc_cs_n=1, adc_sclk=0.
  - start=1 at edge E0 -> CS_SETUP; busy=1 and adc_cs_n=0 from E0.
  - Clear the shift register and bit counter at E0.
- CS_SETUP: hold for SCLK_DIV cycles -> SHIFT at E0+SCLK_DIV.
- SHIFT:
  - adc_sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles, repeated 14 times.
  - On the edge where adc_sclk goes 0->1, shift enable=1 and select=0: q[k] <= q[k-1], q[0] <= adc_sdo.
  - The n-th rising edge (n=1..14) is at E0+(2n)*SCLK_DIV.
  - After the 14th high half-period, at E0+29*SCLK_DIV -> DONE.
- DONE (single cycle):
  - adc_sclk=0 and adc_cs_n=1 at E0+29*SCLK_DIV.
  - sample_data <= shift register; sample_valid=1 at that same edge.
  - Latency from start acceptance to sample_valid: 29*SCLK_DIV cycles (116 at default).
  - Next state QUIET.
- QUIET:
  - Count QUIET_CYCLES cycles (zero means skip), then busy=0 -> IDLE.
  - First possible new start acceptance is at E0+29*SCLK_DIV+QUIET_CYCLES+1.
- Handshake:
  - Transfer occurs on an edge with sample_valid=1 and sample_ready=1; sample_valid drops after it unless a new sample loads on the same edge.
  - sample_data must not change while sample_valid=1 except on a DONE load.
  - DONE load while sample_valid=1 and sample_ready=0: new data overwrites, sample_valid stays 1, overrun <= 1.
  - DONE load with sample_ready=1 on the same edge: old sample is consumed, new sample is valid, no overrun.
  - overrun clears only on reset.
- start is ignored outside IDLE; a start held high continuously yields back-to-back conversions separated by QUIET.
- adc_sdo is not sampled while adc_cs_n=1.

Optional Feature:
- Macro: SONAR_ADC_TEST_PATTERN_EN.
- Defined:
  - A 14-bit pattern counter resets to 0 and increments by 1 (wrapping 16383->0) on every DONE.
  - In DONE with test_mode=1, the shift register is parallel-loaded (select=1) with the counter value; that value becomes sample_data.
  - adc_cs_n and adc_sclk timing are unchanged.
- Undefined: test_mode is ignored, sample_data always comes from adc_sdo, and no counter logic exists.

Test Plan:
- Reset, SCLK_DIV=4, pulse start, ADC model drives 14'h2A5C MSB-first -> adc_cs_n low 116 cycles, 14 sclk rising edges at E0+8, E0+16, ... E0+112, sample_valid at E0+116 with sample_data=14'h2A5C.
- Three back-to-back conversions with start held high, QUIET_CYCLES=2 -> next acceptance 3 cycles after each DONE, adc_cs_n high for exactly 3 cycles between conversions, data 14'h0000, 14'h3FFF, 14'h1555 correct.
- sample_ready=0 through two conversions (14'h0001 then 14'h0002) -> sample_data=14'h0002, overrun=1; a later reset clears overrun.
- sample_ready=1 exactly on the DONE edge of the second conversion -> no overrun, sample_valid stays 1 with the new data.
- Reset asserted at bit 7 of SHIFT -> next edge adc_cs_n=1, adc_sclk=0, busy=0, sample_valid=0; a fresh start then captures 14'h1234 correctly.
- With SONAR_ADC_TEST_PATTERN_EN and test_mode=1, four conversions -> samples 0, 1, 2, 3 regardless of adc_sdo; without the macro, adc_sdo data is returned.
